handshake_tx_fsm: RTL and testbench

//  Transmit side of the 4-phase req/ack handshake toward the Pico: the FPGA drives data + req, the Pico answers on ack.

---
 rtl/handshake_tx_fsm.sv | 135 +++++++++++++
 tb/tb_handshake_tx_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx_fsm.sv
// Transmit side of the 4-phase req/ack handshake toward the Pico.
// Takes words over valid/ready and runs one full req/ack cycle per word; it aborts if ack never rises.
module handshake_tx_fsm #(
  parameter int DATA_WIDTH     = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  req,
  input  logic                  ack,
  output logic                  done_pulse,
  output logic                  timeout_err
);

  localparam int CNT_W  = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TOUT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    SETUP         = 2'd1,
    WAIT_ACK_HIGH = 2'd2,
    WAIT_ACK_LOW  = 2'd3
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [TCNT_W-1:0]     tcnt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  req_r;
  logic                  done_r;
  logic                  timeout_r;
  logic                  aborted_r;
  logic                  ack_s1_r;
  logic                  ack_s2_r;

  assign data        = data_r;
  assign req         = req_r;
  assign done_pulse  = done_r;
  assign timeout_err = timeout_r;
  assign tx_ready    = (state_r == IDLE) && !ack_s2_r;

  // Two-flop synchroniser for the asynchronous ack from the Pico
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_s1_r <= 1'b0;
      ack_s2_r <= 1'b0;
    end else begin
      ack_s1_r <= ack;
      ack_s2_r <= ack_s1_r;
    end
  end

  // Handshake sequencer: state, counters and every registered output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      tcnt_r    <= {TCNT_W{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      req_r     <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            data_r <= tx_data;
            cnt_r  <= {CNT_W{1'b0}};
            tcnt_r <= {TCNT_W{1'b0}};
            if (SETUP_CYCLES == 0) begin
              req_r   <= 1'b1;
              state_r <= WAIT_ACK_HIGH;
            end else begin
              state_r <= SETUP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            req_r   <= 1'b1;
            tcnt_r  <= {TCNT_W{1'b0}};
            state_r <= WAIT_ACK_HIGH;
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        WAIT_ACK_HIGH: begin
          // A real ack takes priority over a timeout expiring in the same clock
          if (ack_s2_r) begin
            req_r     <= 1'b0;
            aborted_r <= 1'b0;
            state_r   <= WAIT_ACK_LOW;
          end else if ((TIMEOUT_CYCLES != 0) && (tcnt_r == TOUT_LAST)) begin
            req_r     <= 1'b0;
            timeout_r <= 1'b1;
            aborted_r <= 1'b1;
            state_r   <= WAIT_ACK_LOW;
          end else if (tcnt_r != {TCNT_W{1'b1}}) begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end else begin
            tcnt_r <= tcnt_r;
          end
        end
        WAIT_ACK_LOW: begin
          req_r <= 1'b0;
          if (!ack_s2_r) begin
            done_r  <= !aborted_r;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_ACK_LOW;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_tx_fsm.sv
// Bench for handshake_tx_fsm: a Pico responder with randomised timing, and a cycle-arithmetic
// model of when req, done_pulse, timeout_err and tx_ready must change.
module tb_handshake_tx_fsm;

  localparam int S  = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] data;
  logic       req;
  logic       ack;
  logic       done_pulse;
  logic       timeout_err;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  handshake_tx_fsm #(.DATA_WIDTH(4), .SETUP_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data(data), .req(req), .ack(ack), .done_pulse(done_pulse), .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; cyc numbers that edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Responder ack level driven just after edge c: up from d edges after req rose until drop_at
  function automatic bit ack_sched(input int c, input int r, input int d, input int drop_at);
    return (d >= 0) && (c >= r + d) && (c < drop_at);
  endfunction

  // One word: d<0 means the Pico never answers; the Pico drops ack h edges after
  // the later of its own rise and req falling. keep leaves tx_valid high carrying nxt.
  task automatic send_word(input logic [3:0] w, input int d, input int h, input bit keep,
                           input logic [3:0] nxt);
    int k, r, f, f_exp, drop_at, e_exp, end_c;
    bit aborted;
    k = 0;
    while (!tx_ready && k < 200) begin
      step();
      k++;
    end
    check_eq("ready_before_word", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    step();
    tx_valid = keep;
    tx_data  = keep ? nxt : 4'($urandom);
    check_eq("data_on_accept", data, w);
    k = 0;
    while (!req && k < 40) begin
      check_eq("ready_low_setup", tx_ready, 0);
      step();
      k++;
    end
    check_eq("req_rise_latency", k, S);
    r = cyc;
    // ack is seen by the FSM three edges after it is driven; timeout fires TO edges after req rose
    aborted = !((d >= 0) && (d + 3 <= TO));
    f_exp   = aborted ? r + TO : r + d + 3;
    drop_at = 1 << 30;
    while (req && (cyc - r) < 100) begin
      check_eq("data_stable_req", data, w);
      check_eq("no_pulse_req_high", done_pulse | timeout_err, 0);
      ack = ack_sched(cyc, r, d, drop_at);
      step();
    end
    f = cyc;
    check_eq("req_fall_cycle", f - r, f_exp - r);
    drop_at = ((r + d > f) ? r + d : f) + h;
    e_exp = f + 1;
    while (ack_sched(e_exp - 3, r, d, drop_at)) e_exp++;
    end_c = ((d >= 0) && (drop_at + 2 > e_exp)) ? drop_at + 2 : e_exp;
    forever begin
      check_eq("req_low", req, 0);
      check_eq("data_hold", data, w);
      check_eq("tx_ready", tx_ready, (cyc >= e_exp) && !ack_sched(cyc - 2, r, d, drop_at));
      check_eq("done_pulse", done_pulse, (cyc == e_exp) && !aborted);
      check_eq("timeout_err", timeout_err, (cyc == f) && aborted);
      ack = ack_sched(cyc, r, d, drop_at);
      if (cyc >= end_c) break;
      step();
    end
  endtask

  initial begin
    int k, c0, dr, dd, hh;
    bit kp;
    reset_n  = 1'b0;
    ack      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 4'h0;
    repeat (3) step();
    check_eq("rst_data", data, 0);
    check_eq("rst_req", req, 0);
    check_eq("rst_done", done_pulse, 0);
    check_eq("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    step();
    check_eq("ready_after_rst", tx_ready, 1);

    send_word(4'hA, 3, 2, 1'b0, 4'h0);
    send_word(4'h1, 2, 1, 1'b1, 4'h2);
    send_word(4'h2, 0, 0, 1'b1, 4'h3);
    send_word(4'h3, 5, 3, 1'b0, 4'h0);
    send_word(4'hC, -1, 0, 1'b0, 4'h0);
    send_word(4'hD, 14, 5, 1'b0, 4'h0);
    send_word(4'hE, 13, 0, 1'b0, 4'h0);
    send_word(4'h6, 20, 5, 1'b0, 4'h0);

    for (int i = 0; i < 60; i++) begin
      dr = $urandom_range(0, 21);
      dd = (dr == 21) ? -1 : dr;
      hh = $urandom_range(0, 4);
      kp = (dd < 16) && ($urandom_range(0, 1) == 1);
      send_word(4'($urandom), dd, hh, kp, 4'($urandom));
    end

    // Reset while req is high
    tx_data  = 4'h9;
    tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 200) begin
      step();
      k++;
    end
    step();
    tx_valid = 1'b0;
    k = 0;
    while (!req && k < 40) begin
      step();
      k++;
    end
    check_eq("mid_req_high", req, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req", req, 0);
    check_eq("mid_rst_data", data, 0);
    step();
    step();
    reset_n = 1'b1;
    send_word(4'h5, 4, 2, 1'b0, 4'h0);

    // ack already high when reset releases
    reset_n = 1'b0;
    step();
    step();
    c0      = cyc;
    ack     = 1'b1;
    reset_n = 1'b1;
    while (cyc < c0 + 8) begin
      check_eq("stuck_ready", tx_ready, !((cyc - 2 >= c0) && (cyc - 2 < c0 + 6)));
      check_eq("stuck_no_err", timeout_err | done_pulse, 0);
      if (cyc >= c0 + 2) check_eq("stuck_ignored", data, 0);
      if (cyc == c0 + 2) begin
        tx_valid = 1'b1;
        tx_data  = 4'h7;
      end
      ack = (cyc < c0 + 6);
      step();
    end
    check_eq("stuck_ready_return", tx_ready, 1);
    send_word(4'h7, 1, 1, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
